core_bus_arbiter: RTL and testbench

//  Sits directly downstream of the core: merges its instruction bus (ibus) and data bus (dbus)

---
 rtl/core_bus_arbiter_if.sv | 84 ++++++++
 rtl/core_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_arbiter_if.sv
// core_bus_arbiter_pkg / core_bus_arbiter_if
//   Bus types shared by the core-side ibus/dbus, the memory-side cbus, and the
//   interface bundle that carries them into core_bus_arbiter.
// Interface signals:
//   ireq   ibus_req_t    core fetch request  {valid, addr}
//   iresp  ibus_resp_t   fetch response      {addr_ok, data_ok, data[31:0]}
//   dreq   dbus_req_t    core data request   {valid, addr, size, strobe, data}
//   dresp  dbus_resp_t   data response       {addr_ok, data_ok, data[63:0]}
//   oreq   cbus_req_t    memory request      {valid, is_write, size, addr, strobe, data, len, burst}
//   oresp  cbus_resp_t   memory response     {ready, last, data}
// Modports:
//   slave  - the arbiter side (takes core requests, drives memory requests)
//   master - the environment side (core + memory model)
package core_bus_arbiter_pkg;

  localparam logic [2:0] MSIZE4          = 3'd2;
  localparam logic [7:0] MLEN1           = 8'd0;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

interface core_bus_arbiter_if;
  import core_bus_arbiter_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport slave (
    input  ireq, dreq, oresp,
    output iresp, dresp, oreq
  );

  modport master (
    output ireq, dreq, oresp,
    input  iresp, dresp, oreq
  );

endinterface

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
//   Merges the core's instruction bus and data bus onto one memory bus.
//   One single-beat transaction is outstanding at a time: a master is granted
//   in IDLE, its request is latched and presented on oreq until the memory
//   returns ready & last, and the response is routed back combinationally in
//   that same cycle.
// Parameters:
//   IDLE_GAP  minimum number of cycles with oreq.valid low between two
//             transactions (0..3); the arbitration cycle in IDLE counts as one
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous, active-high
//   bus    core_bus_arbiter_if.slave (ireq/dreq/oresp in, iresp/dresp/oreq out)
// Build option:
//   BUS_ARB_RR_EN  round-robin between ibus and dbus on simultaneous requests;
//                  when undefined dbus always wins.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int IDLE_GAP = 0
) (
  input logic             clk,
  input logic             reset,
  core_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, GAP} state_t;

  // The IDLE cycle already gives one quiet cycle, so GAP only has to supply
  // the remaining IDLE_GAP-1 cycles; GAP_LAST is the final count in GAP.
  localparam bit         USE_GAP  = (IDLE_GAP >= 2);
  localparam logic [1:0] GAP_LAST = (IDLE_GAP >= 2) ? 2'(IDLE_GAP - 2) : 2'd0;

  state_t     state, state_nxt;
  cbus_req_t  req_q, req_nxt;
  logic [1:0] gap_cnt, gap_cnt_nxt;
  logic       grant_d, grant_i;
  logic       done;
  cbus_req_t  oreq_c;
  ibus_resp_t iresp_c;
  dbus_resp_t dresp_c;

  // A transaction completes on the final beat; reset suppresses the response
  // so an abandoned request never sees data_ok.
  assign done = bus.oresp.ready & bus.oresp.last & ~reset;

`ifdef BUS_ARB_RR_EN
  logic last_grant_d;

  // On a tie, the master that was not granted last time wins.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (bus.dreq.valid && bus.ireq.valid) begin
      grant_d = ~last_grant_d;
      grant_i = last_grant_d;
    end else begin
      grant_d = bus.dreq.valid;
      grant_i = bus.ireq.valid;
    end
  end

  // Last-grant history, 0 = ibus; only updated when a grant is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && (grant_d || grant_i)) begin
      last_grant_d <= grant_d;
    end
  end
`else
  assign grant_d = bus.dreq.valid;
  assign grant_i = bus.ireq.valid & ~bus.dreq.valid;
`endif

  // State, latched request and gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      gap_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Next-state and output decode. Master inputs are only looked at in IDLE.
  always_comb begin
    state_nxt   = state;
    req_nxt     = req_q;
    gap_cnt_nxt = gap_cnt;
    oreq_c      = '0;
    iresp_c     = '0;
    dresp_c     = '0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          req_nxt          = '0;
          req_nxt.valid    = 1'b1;
          req_nxt.is_write = |bus.dreq.strobe;
          req_nxt.size     = bus.dreq.size;
          req_nxt.addr     = bus.dreq.addr;
          req_nxt.strobe   = bus.dreq.strobe;
          req_nxt.data     = bus.dreq.data;
          req_nxt.len      = MLEN1;
          req_nxt.burst    = AXI_BURST_FIXED;
          state_nxt        = BUSY_D;
        end else if (grant_i) begin
          req_nxt          = '0;
          req_nxt.valid    = 1'b1;
          req_nxt.is_write = 1'b0;
          req_nxt.size     = MSIZE4;
          req_nxt.addr     = bus.ireq.addr;
          req_nxt.len      = MLEN1;
          req_nxt.burst    = AXI_BURST_FIXED;
          state_nxt        = BUSY_I;
        end
      end

      BUSY_I: begin
        oreq_c = req_q;
        if (done) begin
          iresp_c.addr_ok = 1'b1;
          iresp_c.data_ok = 1'b1;
          // 32-bit fetch word is picked from the 64-bit beat by addr[2].
          iresp_c.data    = req_q.addr[2] ? bus.oresp.data[63:32] : bus.oresp.data[31:0];
          state_nxt       = USE_GAP ? GAP : IDLE;
          gap_cnt_nxt     = 2'd0;
        end
      end

      BUSY_D: begin
        oreq_c = req_q;
        if (done) begin
          dresp_c.addr_ok = 1'b1;
          dresp_c.data_ok = 1'b1;
          dresp_c.data    = bus.oresp.data;
          state_nxt       = USE_GAP ? GAP : IDLE;
          gap_cnt_nxt     = 2'd0;
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 2'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.oreq  = oreq_c;
  assign bus.iresp = iresp_c;
  assign bus.dresp = dresp_c;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter
//   Self-checking bench for core_bus_arbiter. The bench plays both the core
//   (ibus/dbus masters) and the memory. A transaction-level model keeps the
//   pending request of each master, decides the winner from the arbitration
//   rule, and derives the expected memory request and response.
//   dut uses IDLE_GAP=0; dut_gap uses IDLE_GAP=2 for the gap check.
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  core_bus_arbiter_if bus ();
  core_bus_arbiter_if bus2 ();

  core_bus_arbiter #(.IDLE_GAP(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  core_bus_arbiter #(.IDLE_GAP(2)) dut_gap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: one pending request per master plus the last winner (1 = dbus).
  logic        i_pend;
  logic [63:0] i_addr;
  logic        d_pend;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_data;
  logic        last_was_d;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic pick_d();
    if (d_pend && i_pend) begin
`ifdef BUS_ARB_RR_EN
      return ~last_was_d;
`else
      return 1'b1;
`endif
    end
    return d_pend;
  endfunction

  task automatic new_ireq();
    i_pend = 1'b1;
    i_addr = rand64();
  endtask

  task automatic new_dreq();
    d_pend   = 1'b1;
    d_addr   = rand64();
    d_size   = 3'($urandom_range(0, 3));
    d_strobe = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
    d_data   = rand64();
  endtask

  task automatic drive_masters();
    bus.ireq.valid  = i_pend;
    bus.ireq.addr   = i_addr;
    bus.dreq.valid  = d_pend;
    bus.dreq.addr   = d_addr;
    bus.dreq.size   = d_size;
    bus.dreq.strobe = d_strobe;
    bus.dreq.data   = d_data;
  endtask

  // Compares the DUT outputs at the current sample point. When not busy only
  // oreq.valid is required to be low; ibus request data is not compared.
  task automatic checkOutput(input string tag, input bit busy, input cbus_req_t exp_req,
                             input bit mask_data, input ibus_resp_t exp_i, input dbus_resp_t exp_d);
    cbus_req_t obs;
    obs = bus.oreq;
    if (mask_data) obs.data = '0;
    checks++;
    if (busy) begin
      assert (obs === exp_req) else begin
        errors++;
        $error("[TB] FAIL %s oreq observed=%h expected=%h", tag, obs, exp_req);
      end
    end else begin
      assert (obs.valid === 1'b0) else begin
        errors++;
        $error("[TB] FAIL %s oreq.valid observed=%b expected=0", tag, obs.valid);
      end
    end
    checks++;
    assert (bus.iresp === exp_i) else begin
      errors++;
      $error("[TB] FAIL %s iresp observed=%h expected=%h", tag, bus.iresp, exp_i);
    end
    checks++;
    assert (bus.dresp === exp_d) else begin
      errors++;
      $error("[TB] FAIL %s dresp observed=%h expected=%h", tag, bus.dresp, exp_d);
    end
  endtask

  // One complete transaction starting in IDLE (called #1 after a posedge).
  // waits: cycles before the final beat; mode 0 = ready low, 1 = ready
  // without last, 2 = random mix of both.
  task automatic applyStimulus(input string tag, input int waits, input int mode,
                               input logic [63:0] rdata);
    logic       g;
    cbus_req_t  exp;
    ibus_resp_t ei;
    dbus_resp_t ed;

    drive_masters();
    // Memory noise while idle must be ignored.
    bus.oresp.ready = 1'($urandom_range(0, 1));
    bus.oresp.last  = 1'($urandom_range(0, 1));
    bus.oresp.data  = rand64();

    g = pick_d();
    exp       = '0;
    exp.valid = 1'b1;
    exp.len   = MLEN1;
    exp.burst = AXI_BURST_FIXED;
    if (g) begin
      exp.addr     = d_addr;
      exp.is_write = |d_strobe;
      exp.size     = d_size;
      exp.strobe   = d_strobe;
      exp.data     = d_data;
    end else begin
      exp.addr     = i_addr;
      exp.is_write = 1'b0;
      exp.size     = MSIZE4;
    end

    @(negedge clk);
    checkOutput({tag, "_idle"}, 1'b0, exp, ~g, '0, '0);
    @(posedge clk); #1;
    last_was_d = g;

    // The granted master changes its request mid-transaction; no effect allowed.
    if (g) begin
      bus.dreq.addr = ~d_addr;
      bus.dreq.data = rand64();
    end else begin
      bus.ireq.addr = ~i_addr;
    end

    for (int w = 0; w < waits; w++) begin
      bus.oresp.ready = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.oresp.last  = 1'b0;
      bus.oresp.data  = rand64();
      @(negedge clk);
      checkOutput({tag, "_wait"}, 1'b1, exp, ~g, '0, '0);
      @(posedge clk); #1;
    end

    bus.oresp.ready = 1'b1;
    bus.oresp.last  = 1'b1;
    bus.oresp.data  = rdata;
    ei = '0;
    ed = '0;
    if (g) begin
      ed.addr_ok = 1'b1;
      ed.data_ok = 1'b1;
      ed.data    = rdata;
    end else begin
      ei.addr_ok = 1'b1;
      ei.data_ok = 1'b1;
      ei.data    = exp.addr[2] ? rdata[63:32] : rdata[31:0];
    end
    @(negedge clk);
    checkOutput({tag, "_done"}, 1'b1, exp, ~g, ei, ed);
    @(posedge clk); #1;

    bus.oresp = '0;
    if (g) d_pend = 1'b0;
    else   i_pend = 1'b0;
    drive_masters();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit   found;
    int   gap;
    cbus_req_t z;

    reset      = 1'b1;
    bus.ireq   = '0;
    bus.dreq   = '0;
    bus.oresp  = '0;
    bus2.ireq  = '0;
    bus2.dreq  = '0;
    bus2.oresp = '0;
    i_pend = 1'b0; i_addr = '0;
    d_pend = 1'b0; d_addr = '0; d_size = '0; d_strobe = '0; d_data = '0;
    last_was_d = 1'b0;
    z = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    assert (bus.oreq === z) else begin
      errors++; $error("[TB] FAIL reset_oreq observed=%h expected=0", bus.oreq);
    end
    checks++;
    assert (bus.iresp === '0 && bus.dresp === '0) else begin
      errors++; $error("[TB] FAIL reset_resp observed=%h/%h expected=0", bus.iresp, bus.dresp);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Store: write because of non-zero strobe
    d_pend = 1'b1; d_addr = 64'h8000_1000; d_size = MSIZE4;
    d_strobe = 8'h0F; d_data = 64'hDEAD_BEEF;
    applyStimulus("store", 1, 0, rand64());

    // Single fetch, answered on the third busy cycle, upper word selected
    i_pend = 1'b1; i_addr = 64'h8000_0004;
    applyStimulus("fetch", 2, 0, 64'h1111_2222_3333_4444);

    // Simultaneous requests, three rounds with both valids kept high
    for (int r = 0; r < 3; r++) begin
      if (!i_pend) new_ireq();
      if (!d_pend) new_dreq();
      applyStimulus("simul", $urandom_range(0, 2), 2, rand64());
    end
    while (i_pend || d_pend) applyStimulus("drain", 0, 0, rand64());

    // Load with two non-last beats before the final one
    new_dreq();
    d_strobe = 8'h00;
    applyStimulus("load", 2, 1, rand64());

    // Reset two cycles into a fetch, then a late last beat
    new_ireq();
    drive_masters();
    @(negedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      assert (bus.oreq.valid === 1'b1 && bus.oreq.addr === i_addr) else begin
        errors++; $error("[TB] FAIL rst_busy observed=%b/%h expected=1/%h",
                         bus.oreq.valid, bus.oreq.addr, i_addr);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    bus.oresp.ready = 1'b1;
    bus.oresp.last  = 1'b1;
    bus.oresp.data  = rand64();
    @(negedge clk);
    checks++;
    assert (bus.iresp.data_ok === 1'b0) else begin
      errors++; $error("[TB] FAIL rst_cycle_data_ok observed=%b expected=0", bus.iresp.data_ok);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    i_pend = 1'b0;
    last_was_d = 1'b0;
    drive_masters();
    @(negedge clk);
    checks++;
    assert (bus.oreq === z) else begin
      errors++; $error("[TB] FAIL rst_after_oreq observed=%h expected=0", bus.oreq);
    end
    checks++;
    assert (bus.iresp === '0 && bus.dresp === '0) else begin
      errors++; $error("[TB] FAIL rst_late_last observed=%h/%h expected=0", bus.iresp, bus.dresp);
    end
    @(posedge clk); #1;
    bus.oresp = '0;
    new_ireq();
    new_dreq();
    applyStimulus("rearb", 1, 2, rand64());
    while (i_pend || d_pend) applyStimulus("rearb_drain", 0, 0, rand64());

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) new_ireq();
      if (!d_pend && $urandom_range(0, 1) == 1) new_dreq();
      if (!i_pend && !d_pend) new_ireq();
      applyStimulus("rand", $urandom_range(0, 3), $urandom_range(0, 2), rand64());
    end
    while (i_pend || d_pend) applyStimulus("rand_drain", 0, 0, rand64());

    // IDLE_GAP=2: back-to-back fetches on the second instance
    bus2.oresp.ready = 1'b1;
    bus2.oresp.last  = 1'b1;
    bus2.oresp.data  = 64'h0123_4567_89AB_CDEF;
    bus2.ireq.valid  = 1'b1;
    bus2.ireq.addr   = 64'h8000_0000;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus2.iresp.data_ok === 1'b1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    assert (found === 1'b1) else begin
      errors++; $error("[TB] FAIL gap_first_data_ok observed=%b expected=1", found);
    end
    @(posedge clk); #1;
    bus2.ireq.addr = 64'h8000_0008;
    gap = 0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus2.oreq.valid === 1'b1) found = 1'b1;
      else gap++;
    end
    checks++;
    assert (found === 1'b1 && gap === 2) else begin
      errors++; $error("[TB] FAIL gap_cycles observed=%0d expected=2", gap);
    end
    checks++;
    assert (bus2.oreq.addr === 64'h8000_0008) else begin
      errors++; $error("[TB] FAIL gap_second_addr observed=%h expected=%h", bus2.oreq.addr, 64'h8000_0008);
    end
    @(posedge clk); #1;
    bus2.ireq  = '0;
    bus2.oresp = '0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
